if_id_stall_ctrl: RTL and testbench

// - Consumer end of the load-use hazard interface: owns the PC register and the IF/ID pipeline register
//   and applies the hold/bubble requests produced by Hazard_detection.
// - Sits between instruction memory and ID; also zeroes ID/EX control on bubble and flushes IF/ID on a taken branch.
// - Tracks stall/flush state, bounds stall length and flags runaway stalls.

---
 rtl/if_id_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_if_id_stall_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stall_ctrl.sv
// PC and IF/ID register owner: applies hazard hold/bubble requests, branch flush, and a stall watchdog.
// Optional STALL_STATS_EN adds free-running stall/flush event counters.
module if_id_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 10,
    parameter int          STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PC_write,
    input  logic              IF_ID_Write,
    input  logic              Control_Select_StallMux,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [31:0]       pc_out,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ctrl_out,
    output logic [1:0]        state,
`ifdef STALL_STATS_EN
    output logic [31:0]       stall_total,
    output logic [31:0]       flush_total,
`endif
    output logic              stall_err
);
    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    state_t           state_q;
    logic             hold;
    logic [31:0]      pc_plus4;

    assign hold     = PC_write | IF_ID_Write;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_plus4;
        instr_d = imem_instr;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        cnt_d   = '0;
        err_d   = err_q | (cnt_q == CNT_MAX);
        if (branch_taken) begin
            pc_d    = branch_target;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (PC_write) begin
                pc_d = pc_q;
            end
            if (IF_ID_Write) begin
                instr_d = instr_q;
                pc4_d   = pc4_q;
                valid_d = valid_q;
            end
        end
        // Counter tracks consecutive PC holds and parks at the limit.
        if (PC_write && !branch_taken) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // FLUSH always lasts one cycle; a branch seen while flushing does not extend it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (branch_taken)  state_q <= ST_FLUSH;
                    else if (hold)     state_q <= ST_STALL;
                    else               state_q <= ST_RUN;
                end
                ST_FLUSH: state_q <= hold ? ST_STALL : ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_total_q, flush_total_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_total_q <= '0;
            flush_total_q <= '0;
        end else begin
            if (PC_write)     stall_total_q <= stall_total_q + 32'd1;
            if (branch_taken) flush_total_q <= flush_total_q + 32'd1;
        end
    end

    assign stall_total = stall_total_q;
    assign flush_total = flush_total_q;
`endif

    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign state       = state_q;
    assign stall_err   = err_q;
    assign id_ctrl_out = (Control_Select_StallMux || !valid_q) ? '0 : id_ctrl_in;
endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Randomized + directed bench for if_id_stall_ctrl against an in-bench behavioural model.
// Define STALL_STATS_EN to also exercise the stall/flush counters.
module tb_if_id_stall_ctrl;
    localparam int CTRL_W    = 10;
    localparam int STALL_MAX = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              PC_write, IF_ID_Write, Control_Select_StallMux, branch_taken;
    logic [31:0]       branch_target, imem_instr;
    logic [CTRL_W-1:0] id_ctrl_in;
    logic [31:0]       pc_out, if_id_instr, if_id_pc4;
    logic              if_id_valid, stall_err;
    logic [CTRL_W-1:0] id_ctrl_out;
    logic [1:0]        state;
`ifdef STALL_STATS_EN
    logic [31:0]       stall_total, flush_total;
`endif

    if_id_stall_ctrl #(.RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .PC_write(PC_write), .IF_ID_Write(IF_ID_Write),
        .Control_Select_StallMux(Control_Select_StallMux), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl_in(id_ctrl_in),
        .pc_out(pc_out), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .id_ctrl_out(id_ctrl_out), .state(state),
`ifdef STALL_STATS_EN
        .stall_total(stall_total), .flush_total(flush_total),
`endif
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural view of the block.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_err;
    int          m_state;     // 0 RUN, 1 STALL, 2 FLUSH
    int          m_run;       // length of the current unbroken PC-hold run
    logic [31:0] m_stall_total, m_flush_total;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge();
        logic [31:0] nxt_pc;
        int          nxt_state;
        if (!rst_n) begin
            m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_state = 0; m_run = 0; m_err = 0;
            m_stall_total = 0; m_flush_total = 0;
            return;
        end
        nxt_pc = branch_taken ? branch_target : (PC_write ? m_pc : m_pc + 32'd4);
        if (branch_taken) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!IF_ID_Write) begin
            m_instr = imem_instr; m_pc4 = m_pc + 32'd4; m_valid = 1;
        end
        if (m_state == 2)      nxt_state = (PC_write || IF_ID_Write) ? 1 : 0;
        else if (branch_taken) nxt_state = 2;
        else                   nxt_state = (PC_write || IF_ID_Write) ? 1 : 0;
        if (m_run >= STALL_MAX) m_err = 1;
        m_run = (PC_write && !branch_taken) ? m_run + 1 : 0;
        m_stall_total += {31'd0, PC_write};
        m_flush_total += {31'd0, branch_taken};
        m_pc    = nxt_pc;
        m_state = nxt_state;
    endtask

    task automatic compare_regs();
        check("pc_out",      {32'd0, pc_out},      {32'd0, m_pc});
        check("if_id_instr", {32'd0, if_id_instr}, {32'd0, m_instr});
        check("if_id_pc4",   {32'd0, if_id_pc4},   {32'd0, m_pc4});
        check("if_id_valid", {63'd0, if_id_valid}, {63'd0, m_valid});
        check("state",       {62'd0, state},       64'(m_state));
        check("stall_err",   {63'd0, stall_err},   {63'd0, m_err});
`ifdef STALL_STATS_EN
        check("stall_total", {32'd0, stall_total}, {32'd0, m_stall_total});
        check("flush_total", {32'd0, flush_total}, {32'd0, m_flush_total});
`endif
    endtask

    // One clock: check the combinational output, take the edge, then check registers.
    task automatic step();
        logic [CTRL_W-1:0] exp_ctrl;
        #1;
        exp_ctrl = (Control_Select_StallMux || !m_valid) ? '0 : id_ctrl_in;
        if (rst_n) check("id_ctrl_out", {54'd0, id_ctrl_out}, {54'd0, exp_ctrl});
        @(posedge clk);
        model_edge();
        #1;
        compare_regs();
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic sm,
                         input logic br, input logic [31:0] tgt);
        rst_n = r; PC_write = pw; IF_ID_Write = iw; Control_Select_StallMux = sm;
        branch_taken = br; branch_target = tgt;
        id_ctrl_in = CTRL_W'($urandom);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1;
    endtask

    initial begin
        imem_instr = 32'h2002_0005;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset and free run.
        do_reset();
        check("lit_reset_pc",    {32'd0, pc_out}, {32'd0, RESET_PC});
        check("lit_reset_valid", {63'd0, if_id_valid}, 64'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            step();
            check("lit_free_pc", {32'd0, pc_out}, 64'(4 * k));
        end
        check("lit_free_valid", {63'd0, if_id_valid}, 64'd1);

        // Load-use stall at pc=8.
        do_reset();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 1, 1, 1, 0, 0);
        #1 check("lit_bubble_ctrl", {54'd0, id_ctrl_out}, 64'd0);
        step();
        check("lit_stall_pc",    {32'd0, pc_out}, 64'd8);
        check("lit_stall_state", {62'd0, state},  64'd1);
        check("lit_stall_pc4",   {32'd0, if_id_pc4}, 64'd8);
        drive(1, 0, 0, 0, 0, 0); step();
        check("lit_resume_pc",    {32'd0, pc_out}, 64'd12);
        check("lit_resume_state", {62'd0, state},  64'd0);

        // Branch wins over an active stall.
        drive(1, 1, 1, 1, 1, 32'h40); step();
        check("lit_br_pc",    {32'd0, pc_out},      64'h40);
        check("lit_br_instr", {32'd0, if_id_instr}, 64'd0);
        check("lit_br_valid", {63'd0, if_id_valid}, 64'd0);
        check("lit_br_state", {62'd0, state},       64'd2);

        // Runaway stall.
        do_reset();
        for (int k = 0; k < STALL_MAX; k++) begin
            drive(1, 1, 0, 0, 0, 0); step();
        end
        check("lit_err_early", {63'd0, stall_err}, 64'd0);
        drive(1, 0, 0, 0, 0, 0); step();
        check("lit_err_set", {63'd0, stall_err}, 64'd1);
        drive(1, 0, 0, 0, 0, 0); step();
        check("lit_err_sticky", {63'd0, stall_err}, 64'd1);

        // PC wrap.
        drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC); step();
        drive(1, 0, 0, 0, 0, 0); step();
        check("lit_wrap_pc", {32'd0, pc_out}, 64'd0);

        // Reset mid-stall.
        drive(1, 1, 1, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0, 0); step();
        check("lit_rst_stall_pc",    {32'd0, pc_out}, {32'd0, RESET_PC});
        check("lit_rst_stall_state", {62'd0, state},  64'd0);
        rst_n = 1;

`ifdef STALL_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin drive(1, 1, 1, 1, 0, 0); step(); end
        for (int k = 0; k < 2; k++) begin drive(1, 0, 0, 0, 1, 32'h100); step(); end
        check("lit_stall_total", {32'd0, stall_total}, 64'd3);
        check("lit_flush_total", {32'd0, flush_total}, 64'd2);
`endif

        // Randomized traffic, including disagreeing holds and long stall bursts.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic pw, iw;
            pw = ($urandom_range(0, 2) == 0);
            iw = ($urandom_range(0, 3) == 0) ? ~pw : pw;
            if ((k % 100) > 80) begin pw = 1; iw = 1; end
            drive(($urandom_range(0, 60) != 0), pw, iw, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0), {$urandom} & 32'hFFFF_FFFC);
            imem_instr = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
